// File: rtl/memory_responder.sv
// -----------------------------------------------------------------------------
// memory_responder
//
// Purpose:
//   Responder end of the mem_execute / mem_ready memory protocol. Holds the
//   noun store in a single-port synchronous RAM (registered read), serves
//   GET_CONTENTS (two sequential reads, one per address) and SET_CONTENTS
//   (one write), and maintains the bump-allocator pointer free_addr.
//
//   Optional feature macro: MEM_BOUNDS_CHECK_EN
//     defined     : any address1 (or address2 on GET) >= DEPTH is rejected with
//                   mem_error[1]; no RAM access, mem_ready pulses at E0+1.
//     not defined : addresses are truncated to $clog2(DEPTH) bits (aliasing);
//                   mem_error[1] only reports a full allocator.
//
// Ports:
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous reset, active low
//   mem_execute  in   1       request strobe, sampled only in IDLE
//   mem_func     in   2       GET_CONTENTS / SET_CONTENTS, other codes illegal
//   address1     in   ADDR_W  read address 1 / write address
//   address2     in   ADDR_W  read address 2 (GET only)
//   write_data   in   DATA_W  SET payload
//   mem_ready    out  1       one-cycle completion pulse
//   read_data1   out  DATA_W  word at address1 (GET)
//   read_data2   out  DATA_W  word at address2 (GET)
//   free_addr    out  ADDR_W  next unallocated word
//   mem_error    out  2       [0] illegal func, [1] out of range / allocator
//                             full; sticky until the next accepted request
//
// Latency from the accepting edge E0 to the rising edge of mem_ready:
//   GET +3, SET +2, illegal/rejected +1.
// -----------------------------------------------------------------------------

`ifndef GET_CONTENTS
`define GET_CONTENTS 2'b00
`endif
`ifndef SET_CONTENTS
`define SET_CONTENTS 2'b01
`endif

module memory_responder #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 1024,
    parameter int FREE_BASE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_execute,
    input  logic [1:0]        mem_func,
    input  logic [ADDR_W-1:0] address1,
    input  logic [ADDR_W-1:0] address2,
    input  logic [DATA_W-1:0] write_data,
    output logic              mem_ready,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [ADDR_W-1:0] free_addr,
    output logic [1:0]        mem_error
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_RD2  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4,
        S_HOLD = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Request captured at the accepting edge
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [ADDR_W-1:0] addr2_q, addr2_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              get_q,   get_d;     // legal GET that will reach DONE via RD2

    // Registered outputs
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic [ADDR_W-1:0] free_q,  free_d;
    logic [1:0]        err_q,   err_d;

    // RAM
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] ram_rd_q;
    logic [IDX_W-1:0]  ram_rd_idx;
    logic [IDX_W-1:0]  ram_wr_idx;
    logic              ram_we;

    // Request decode (only meaningful while IDLE)
    logic req_get;
    logic req_set;
    logic req_legal;
    logic req_oob;
    logic accept;

    assign req_get   = (mem_func == `GET_CONTENTS);
    assign req_set   = (mem_func == `SET_CONTENTS);
    assign req_legal = req_get | req_set;
    assign accept    = (state_q == S_IDLE) && mem_execute;

`ifdef MEM_BOUNDS_CHECK_EN
    // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    assign req_oob = ({1'b0, address1} >= DEPTH_EXT) ||
                     (req_get && ({1'b0, address2} >= DEPTH_EXT));
`else
    assign req_oob = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State register and registered datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr1_q  <= '0;
            addr2_q  <= '0;
            wdata_q  <= '0;
            get_q    <= 1'b0;
            ready_q  <= 1'b0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            free_q   <= ADDR_W'(FREE_BASE);
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr1_q  <= addr1_d;
            addr2_q  <= addr2_d;
            wdata_q  <= wdata_d;
            get_q    <= get_d;
            ready_q  <= ready_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            free_q   <= free_d;
            err_q    <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_execute) begin
                    if (!req_legal || req_oob) begin
                        state_d = S_DONE;
                    end else if (req_get) begin
                        state_d = S_RD1;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_RD1:  state_d = S_RD2;
            S_RD2:  state_d = S_DONE;
            S_WR:   state_d = S_DONE;
            S_DONE: state_d = S_HOLD;
            // A strobe still high from the request just served must not be
            // taken as a fresh request, so wait for it to drop first.
            S_HOLD: if (!mem_execute) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        addr1_d  = addr1_q;
        addr2_d  = addr2_q;
        wdata_d  = wdata_q;
        get_d    = get_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        free_d   = free_q;
        err_d    = err_q;

        // mem_ready is registered on the edge that leaves DONE, so its rising
        // edge lines up with read_data2 becoming valid.
        ready_d  = (state_q == S_DONE);

        if (accept) begin
            addr1_d = address1;
            addr2_d = address2;
            wdata_d = write_data;
            get_d   = req_get && !req_oob;
            err_d   = {req_legal && req_oob, !req_legal};
        end

        // ram_rd_q holds the word at addr1_q (read issued in RD1)
        if (state_q == S_RD2) begin
            rdata1_d = ram_rd_q;
        end

        // ram_rd_q holds the word at addr2_q (read issued in RD2)
        if ((state_q == S_DONE) && get_q) begin
            rdata2_d = ram_rd_q;
        end

        // Bump allocator: writing the current free word claims it. The last
        // word can still be written but the pointer never moves past it.
        if ((state_q == S_WR) && (addr1_q == free_q)) begin
            if (free_q == ADDR_W'(DEPTH - 1)) begin
                err_d[1] = 1'b1;
            end else begin
                free_d = free_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Single-port RAM, registered read. The read port follows addr1_q except
    // in RD2 where it is steered to addr2_q; only the RD1 and RD2 samples are
    // ever consumed.
    // -------------------------------------------------------------------------
    assign ram_we     = (state_q == S_WR);
    assign ram_wr_idx = IDX_W'(addr1_q);
    assign ram_rd_idx = (state_q == S_RD2) ? IDX_W'(addr2_q) : IDX_W'(addr1_q);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_wr_idx] <= wdata_q;
        end
        ram_rd_q <= ram[ram_rd_idx];
    end

    assign mem_ready  = ready_q;
    assign read_data1 = rdata1_q;
    assign read_data2 = rdata2_q;
    assign free_addr  = free_q;
    assign mem_error  = err_q;

endmodule
